// File: rtl/ram_param_pkg.sv
// Shared constants for the parametrised single-port RAM.
//   ST_IDLE / ST_SWEEP : encoding of the one-bit controller state
//   RW_READ / RW_WRITE : encoding of the r_w_i access direction input
package ram_param_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SWEEP = 1'b1;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/ram_param.sv
// Parametrised single-port synchronous RAM with registered read and a
// hardware sweep engine. The sweep clears every word on reset, or fills every
// word with ones on a preset request.
//
// Ports:
//   clk_i     clock, all state changes on posedge
//   clear_i   synchronous active-high reset; starts a zero sweep
//   en_i      access enable, ignored while busy
//   r_w_i     1 = write, 0 = read
//   addr_i    word address
//   in_i      write data
//   preset_i  request an all-ones sweep, sampled only when idle
//   out_o     registered read data, holds the last read value
//   valid_o   one-cycle pulse: out_o was updated by a read on the last edge
//   busy_o    sweep in progress
module ram_param
  import ram_param_pkg::*;
#(
  parameter int unsigned  WIDTH = 4,
  parameter int unsigned  DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             r_w_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] in_i,
  input  logic             preset_i,
  output logic [WIDTH-1:0] out_o,
  output logic             valid_o,
  output logic             busy_o
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  logic             state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic             fill_q, fill_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] out_q;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic             rd_en;

  // Next-state and memory port control; clear_i is applied in the registers
  // and additionally blocks every memory write and read on its edge.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    fill_d    = fill_q;
    valid_d   = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = {WIDTH{fill_q}};
    rd_en     = 1'b0;

    if (state_q == ST_SWEEP) begin
      mem_we = ~clear_i;
      ptr_d  = ptr_q + 1'b1;  // wraps to 0 after the last word
      if (ptr_q == AW'(DEPTH - 1)) begin
        state_d = ST_IDLE;
      end
    end else if (preset_i) begin
      // Preset wins over any access presented on the same edge.
      state_d = ST_SWEEP;
      ptr_d   = '0;
      fill_d  = 1'b1;
    end else if (en_i) begin
      if (r_w_i == RW_WRITE) begin
        mem_we    = ~clear_i;
        mem_waddr = addr_i;
        mem_wdata = in_i;
      end else if (r_w_i == RW_READ) begin
        rd_en   = ~clear_i;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      state_q <= ST_SWEEP;
      ptr_q   <= '0;
      fill_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      out_q <= '0;
    end else if (rd_en) begin
      out_q <= mem[addr_i];
    end
  end

  // Storage has no reset; the sweep defines its contents.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign out_o   = out_q;
  assign valid_o = valid_q;
  assign busy_o  = (state_q == ST_SWEEP);

endmodule

// File: tb/tb_ram_param.sv
// Self-checking bench for ram_param: a behavioural model compared on every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_ram_param;

  localparam int W = 4;
  localparam int D = 16;
  localparam int A = 4;

  logic         clk = 1'b0;
  logic         clear = 1'b1;
  logic         en = 1'b0;
  logic         r_w = 1'b0;
  logic [A-1:0] addr = '0;
  logic [W-1:0] din = '0;
  logic         preset = 1'b0;
  logic [W-1:0] out;
  logic         valid;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  ram_param #(.WIDTH(W), .DEPTH(D)) dut (
    .clk_i   (clk),
    .clear_i (clear),
    .en_i    (en),
    .r_w_i   (r_w),
    .addr_i  (addr),
    .in_i    (din),
    .preset_i(preset),
    .out_o   (out),
    .valid_o (valid),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: sweep is "words still to write", memory is a plain array.
  logic [W-1:0] m_mem [D];
  int           m_left = D;
  logic         m_fill = 1'b0;
  logic [W-1:0] m_out = '0;
  logic         m_valid = 1'b0;

  always @(posedge clk) begin
    if (clear) begin
      m_left = D; m_fill = 1'b0; m_out = '0; m_valid = 1'b0;
    end else if (m_left > 0) begin
      m_mem[D - m_left] = m_fill ? {W{1'b1}} : {W{1'b0}};
      m_left = m_left - 1;
      m_valid = 1'b0;
    end else if (preset) begin
      m_left = D; m_fill = 1'b1; m_valid = 1'b0;
    end else if (en && r_w) begin
      m_mem[addr] = din; m_valid = 1'b0;
    end else if (en) begin
      m_out = m_mem[addr]; m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    chk("model.out", int'(out), int'(m_out));
    chk("model.valid", int'(valid), int'(m_valid));
    chk("model.busy", int'(busy), int'(m_left > 0));
  end

  task automatic drive(input logic c, input logic e, input logic rw, input int a,
                       input int d, input logic p);
    clear = c; en = e; r_w = rw; addr = A'(a); din = W'(d); preset = p;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cnt(output int n);
    n = 0;
    clear = 1'b0; en = 1'b0; preset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (!busy) break;
    end
  endtask

  int n;

  initial begin
    // Reset sweep
    drive(1, 0, 0, 0, 0, 0);
    chk("rst.busy", int'(busy), 1);
    chk("rst.out", int'(out), 0);
    chk("rst.valid", int'(valid), 0);
    drive(1, 1, 0, 0, 0, 0);
    idle_cnt(n);
    chk("rst.sweep_len", n, 16);
    drive(0, 1, 0, 0, 0, 0);
    chk("rst.rd0", int'(out), 0);
    chk("rst.rd0.valid", int'(valid), 1);
    drive(0, 1, 0, 7, 0, 0);
    chk("rst.rd7", int'(out), 0);
    drive(0, 1, 0, 15, 0, 0);
    chk("rst.rd15", int'(out), 0);
    chk("rst.rd15.valid", int'(valid), 1);

    // Write / read
    drive(0, 1, 1, 3, 4'b0011, 0);
    chk("wr.valid", int'(valid), 0);
    drive(0, 1, 1, 15, 4'b1010, 0);
    drive(0, 1, 0, 3, 0, 0);
    chk("rd3", int'(out), 4'b0011);
    chk("rd3.valid", int'(valid), 1);
    drive(0, 1, 0, 15, 0, 0);
    chk("rd15", int'(out), 4'b1010);
    chk("rd15.valid", int'(valid), 1);
    drive(0, 0, 0, 0, 0, 0);
    chk("hold.out", int'(out), 4'b1010);
    chk("hold.valid", int'(valid), 0);

    // Read after write
    drive(0, 1, 1, 9, 4'b0101, 0);
    drive(0, 1, 0, 9, 0, 0);
    chk("raw9", int'(out), 4'b0101);

    // Preset fill, same-edge write is dropped
    drive(0, 1, 1, 2, 4'b0001, 1);
    chk("preset.busy", int'(busy), 1);
    idle_cnt(n);
    chk("preset.sweep_len", n, 16);
    drive(0, 1, 0, 2, 0, 0);
    chk("preset.rd2", int'(out), 4'b1111);
    drive(0, 1, 0, 0, 0, 0);
    chk("preset.rd0", int'(out), 4'b1111);

    // Clear mid-sweep, with a read attempted during the restarted sweep
    drive(0, 0, 0, 0, 0, 1);
    repeat (4) drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 5, 0, 0);
    chk("lock.valid", int'(valid), 0);
    chk("lock.out", int'(out), 0);
    idle_cnt(n);
    chk("clr.sweep_len", n, 15);  // one of the 16 edges was the locked read
    drive(0, 1, 0, 0, 0, 0);
    chk("clr.rd0", int'(out), 0);
    drive(0, 1, 0, 12, 0, 0);
    chk("clr.rd12", int'(out), 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive(logic'($urandom_range(0, 99) == 0), logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 1)), int'($urandom_range(0, D - 1)),
            int'($urandom_range(0, 15)), logic'($urandom_range(0, 49) == 0));
    end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
